mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 single-bit mux (the select lines s2/s1/s0 of the 8-input mux) among eight requesters.
- Each requester i owns mux input i. The arbiter decides which input is routed to the mux output z, and for how long.
- It is intended as the sequencer for shared single-bit resources in the processor datapath, e.g. a shared status/flag line.

---
 rtl/mux8_rr_arbiter_if.sv | 14 +
 rtl/mux8_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side bundle for the shared 8:1 mux arbiter: request vector in, grant and mux select out.
// The master modport is the requester pool and the slave modport is the arbiter.
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] grant;
   logic       s2;
   logic       s1;
   logic       s0;
   logic       busy;
   logic       timeout;

   modport master (output req, input grant, s2, s1, s0, busy, timeout);
   modport slave  (input req, output grant, s2, s1, s0, busy, timeout);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner sequencer for a shared 8:1 single-bit mux, with a hold timeout.
// One cycle from req to grant/select; requesters wait by holding req high, no other backpressure.
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input logic              clk,
   input logic              rst,
   mux8_rr_arbiter_if.slave arb
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [7:0]       grant_q, grant_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic             timeout_q, timeout_d;

   logic [3:0] idle_pick;
   logic [3:0] next_pick;
   logic       owner_req;
   logic       others;

   // Returns {found, index} of the first set bit scanning base, base+1, ... modulo 8.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int i = 7; i >= 0; i--) begin
         idx = base + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign idle_pick = rr_pick(arb.req, ptr_q);
   // Owner masked out so a forced rotation cannot hand the grant straight back.
   assign next_pick = rr_pick(arb.req & ~grant_q, sel_q + 3'd1);
   assign owner_req = |(arb.req & grant_q);
   assign others    = |(arb.req & ~grant_q);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (idle_pick[3]) begin
               state_d = GRANT;
               grant_d = 8'b1 << idle_pick[2:0];
               sel_d   = idle_pick[2:0];
               hcnt_d  = '0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               ptr_d  = sel_q + 3'd1;
               hcnt_d = '0;
               if (next_pick[3]) begin
                  grant_d = 8'b1 << next_pick[2:0];
                  sel_d   = next_pick[2:0];
               end else begin
                  state_d = IDLE;
                  grant_d = 8'b0;
               end
            end else if (!others) begin
               if (hcnt_q < HOLD_SAT) hcnt_d = hcnt_q + CNT_W'(1);
            end else if ((MAX_HOLD != 0) && (hcnt_q >= HOLD_LAST)) begin
               // Counter may already sit at saturation if competitors just arrived.
               grant_d   = 8'b1 << next_pick[2:0];
               sel_d     = next_pick[2:0];
               ptr_d     = sel_q + 3'd1;
               hcnt_d    = '0;
               timeout_d = 1'b1;
            end else begin
               hcnt_d = hcnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= 8'b0;
         sel_q     <= 3'b000;
         ptr_q     <= 3'b000;
         hcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb.grant   = grant_q;
   assign arb.s2      = sel_q[2];
   assign arb.s1      = sel_q[1];
   assign arb.s0      = sel_q[0];
   assign arb.busy    = (state_q == GRANT);
   assign arb.timeout = timeout_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench: an ownership model predicts each cycle's outputs into a queue, a monitor pops and compares.
module tb_mux8_rr_arbiter;
   localparam int MAX_HOLD = 4;

   typedef struct {
      logic [7:0] grant;
      logic [2:0] sel;
      logic       busy;
      logic       timeout;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t exp_q[$];

   // Reference state: who owns the mux, for how many cycles, and where the next search starts.
   int   m_owner;
   int   m_held;
   int   m_ptr;
   int   m_sel;
   logic m_to;

   mux8_rr_arbiter_if bus ();

   mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
      .clk(clk),
      .rst(rst),
      .arb(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int search(input logic [7:0] r, input int start, input int skip);
      for (int off = 0; off < 8; off++) begin
         int idx;
         idx = (start + off) % 8;
         if (idx != skip && r[idx]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      exp_t       e;
      logic [7:0] r;
      int         k;
      int         w;
      if (rst) begin
         m_owner = -1;
         m_held  = 0;
         m_ptr   = 0;
         m_sel   = 0;
         m_to    = 1'b0;
      end else begin
         r    = bus.req;
         m_to = 1'b0;
         if (m_owner < 0) begin
            w = search(r, m_ptr, -1);
            if (w >= 0) begin
               m_owner = w;
               m_held  = 1;
               m_sel   = w;
            end
         end else begin
            k = m_owner;
            if (!r[k] || ((MAX_HOLD != 0) && (m_held >= MAX_HOLD) && search(r, k, k) >= 0)) begin
               m_to    = r[k];
               m_ptr   = (k + 1) % 8;
               w       = search(r, m_ptr, k);
               m_owner = w;
               m_held  = 1;
               if (w >= 0) m_sel = w;
            end else begin
               m_held = m_held + 1;
            end
         end
      end
      if (clk) begin
         e.grant   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
         e.sel     = 3'(m_sel);
         e.busy    = (m_owner >= 0);
         e.timeout = m_to;
         exp_q.push_back(e);
      end
   end

   // Monitor: clock edges pop the scoreboard; a reset rising while clk is low checks the async clear.
   initial begin
      exp_t       e;
      logic [2:0] sel;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         sel = {bus.s2, bus.s1, bus.s0};
         if (!clk) begin
            n_cmp++;
            if (bus.grant !== 8'h00 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
               n_err++;
               $display("FAIL async_reset t=%0t: grant=%h busy=%b timeout=%b, required grant=00 busy=0 timeout=0",
                        $time, bus.grant, bus.busy, bus.timeout);
            end
         end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty t=%0t: DUT output with no prediction queued", $time);
         end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.grant !== e.grant || sel !== e.sel || bus.busy !== e.busy || bus.timeout !== e.timeout) begin
               n_err++;
               $display("FAIL cycle t=%0t: got grant=%h sel=%b busy=%b timeout=%b, required grant=%h sel=%b busy=%b timeout=%b",
                        $time, bus.grant, sel, bus.busy, bus.timeout, e.grant, e.sel, e.busy, e.timeout);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] prev;
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b1;
      bus.req = 8'hFF;
      #20;
      rst = 1'b0;
      cycles(2);

      // Single requester held then dropped; select must stay at 010 afterwards.
      bus.req = 8'h00;
      cycles(3);
      bus.req = 8'h04;
      cycles(10);
      bus.req = 8'h00;
      cycles(3);

      // Two requesters, each dropping for one cycle right after it wins.
      bus.req = 8'h88;
      prev    = 8'h00;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (bus.grant != prev && bus.grant != 8'h00) bus.req = 8'h88 & ~bus.grant;
         else bus.req = 8'h88;
         prev = bus.grant;
      end
      bus.req = 8'h00;
      cycles(3);

      // Hold timeout: input 5 never lets go, input 1 arrives a cycle after it wins.
      bus.req = 8'h20;
      cycles(2);
      bus.req = 8'h22;
      cycles(10);
      bus.req = 8'h00;
      cycles(3);

      // Wrap-around: owner 7 releases while 6 and 0 are waiting.
      bus.req = 8'h80;
      cycles(2);
      bus.req = 8'h41;
      cycles(3);
      bus.req = 8'h00;
      cycles(3);

      // Reset pulse between edges while input 6 owns the mux.
      bus.req = 8'h40;
      cycles(3);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      cycles(3);

      // Sticky random traffic so holds, releases and rotations all occur.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            case ($urandom_range(2, 0))
               0: bus.req = 8'($urandom) & 8'($urandom);
               1: bus.req = 8'($urandom);
               default: bus.req = 8'h01 << $urandom_range(7, 0);
            endcase
         end
         cycles(1);
      end

      bus.req = 8'h00;
      cycles(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
